alu_pipe_dp: RTL and testbench

- Parametrised successor to the 8-bit single-cycle register-file/ALU datapath.
- Two-stage pipeline: a read/issue stage, then an execute/writeback stage.
- Provides a valid/ready command interface, result backpressure, EX-to-issue forwarding, a widened ALU op set, a sticky flag register and a registered output port.
- Sits between the sequencing FSM (command producer) and downstream consumers of results.

---
 rtl/alu_pipe_dp.sv | 205 ++++++++++++++++++++
 tb/tb_alu_pipe_dp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_dp.sv
// alu_pipe_dp: two-stage register-file / ALU datapath.
//
// Stage 0 (issue): reads the register file, selects operand B (immediate or
// register), forwards the retiring EX result into either operand and hands
// the command to the EX registers on a cmd_valid/cmd_ready handshake.
// Stage 1 (execute/writeback): holds one command, presents its ALU result on
// res_data while res_valid is high, and on retirement (res_valid && res_ready)
// writes the register file, updates the sticky flag register and optionally
// loads out_port.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_op                   ALU opcode (0..10 defined, 11..15 reserved)
//   cmd_rs1/rs2/rd           source A, source B, destination register
//   cmd_imm_sel, cmd_imm     operand B select / immediate value
//   cmd_wr_en, cmd_out_en    write rd / load out_port on retirement
//   res_valid / res_ready    result handshake, res_data = EX result
//   flags                    {ovf, carry, neg, zero} of the last retirement
//   out_port                 registered output port
module alu_pipe_dp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              cmd_imm_sel,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              cmd_wr_en,
    input  logic              cmd_out_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] out_port
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    // ALU result; reserved opcodes produce zero.
    function automatic logic [DATA_W-1:0] alu_result(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic        [SH_W-1:0]   sh;
        logic        [DATA_W-1:0] r;
        a_s = $signed(a);
        b_s = $signed(b);
        sh  = b[SH_W-1:0];
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SHL:   r = a << sh;
            OP_SHR:   r = a >> sh;
            OP_SRA:   r = $unsigned(a_s >>> sh);
            OP_SLTU:  r = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLT:   r = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_PASSB: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // {ovf, carry, neg, zero}; carry/ovf only meaningful for ADD and SUB.
    function automatic logic [3:0] alu_flags(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] r
    );
        logic [DATA_W:0] sum;
        logic            carry;
        logic            ovf;
        sum   = {1'b0, a} + {1'b0, b};
        carry = 1'b0;
        ovf   = 1'b0;
        if (op == OP_ADD) begin
            carry = sum[DATA_W];
            ovf   = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
        end else if (op == OP_SUB) begin
            carry = (a < b);
            ovf   = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
        end
        return {ovf, carry, r[MSB], (r == '0)};
    endfunction

    logic [DATA_W-1:0] rf_q [NREG];

    logic              ex_valid_q;
    logic              ex_valid_d;
    logic [3:0]        ex_op_q;
    logic [DATA_W-1:0] ex_a_q;
    logic [DATA_W-1:0] ex_b_q;
    logic [ADDR_W-1:0] ex_rd_q;
    logic              ex_wr_q;
    logic              ex_out_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] out_q;

    logic              ex_fire;
    logic              accept;
    logic              fwd_hit;
    logic              op_rsvd;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opa_d;
    logic [DATA_W-1:0] opb_d;
    logic [3:0]        flags_d;

    // ---- Stage 0: issue / operand read ----
    assign ex_fire   = ex_valid_q && res_ready;
    assign cmd_ready = !ex_valid_q || ex_fire;
    assign accept    = cmd_valid && cmd_ready;
    assign op_rsvd   = (cmd_op > OP_PASSB);

    // Only a retiring command that really writes a non-zero rd can forward;
    // reserved ops already had wr_en cleared when they entered EX.
    assign fwd_hit = ex_fire && ex_wr_q && (ex_rd_q != '0);

    always_comb begin
        rf_a  = (cmd_rs1 == '0) ? '0 : rf_q[cmd_rs1];
        rf_b  = (cmd_rs2 == '0) ? '0 : rf_q[cmd_rs2];
        opa_d = (fwd_hit && (ex_rd_q == cmd_rs1)) ? res_data : rf_a;
        if (cmd_imm_sel) begin
            opb_d = cmd_imm;
        end else begin
            opb_d = (fwd_hit && (ex_rd_q == cmd_rs2)) ? res_data : rf_b;
        end
        if (accept) begin
            ex_valid_d = 1'b1;
        end else begin
            ex_valid_d = ex_valid_q && !res_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ex_op_q  <= cmd_op;
            ex_a_q   <= opa_d;
            ex_b_q   <= opb_d;
            ex_rd_q  <= cmd_rd;
            ex_wr_q  <= cmd_wr_en && !op_rsvd;
            ex_out_q <= cmd_out_en && !op_rsvd;
        end
    end

    // ---- Stage 1: execute / writeback ----
    assign res_valid = ex_valid_q;
    assign res_data  = alu_result(ex_op_q, ex_a_q, ex_b_q);
    assign flags_d   = alu_flags(ex_op_q, ex_a_q, ex_b_q, res_data);
    assign flags     = flags_q;
    assign out_port  = out_q;

    // Reset clears ex_valid asynchronously, so an in-flight command can never
    // fire afterwards: no writeback, flag or out_port update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            flags_q    <= 4'd0;
            out_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (ex_fire) begin
                flags_q <= flags_d;
                if (ex_out_q) begin
                    out_q <= res_data;
                end
            end
        end
    end

    // Register file has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ex_fire && ex_wr_q && (ex_rd_q != '0)) begin
            rf_q[ex_rd_q] <= res_data;
        end
    end

endmodule

// File: tb/tb_alu_pipe_dp.sv
module tb_alu_pipe_dp;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [2:0] cmd_rs1;
    logic [2:0] cmd_rs2;
    logic [2:0] cmd_rd;
    logic       cmd_imm_sel;
    logic [7:0] cmd_imm;
    logic       cmd_wr_en;
    logic       cmd_out_en;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] flags;
    logic [7:0] out_port;

    alu_pipe_dp #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
        .cmd_wr_en(cmd_wr_en), .cmd_out_en(cmd_out_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .flags(flags), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Architectural reference: sequential execution of accepted commands.
    typedef struct {
        logic [7:0] res;
        logic [3:0] fl;
        logic [2:0] rd;
        logic       wr;
        logic       out;
    } exp_t;

    exp_t       q[$];
    logic [7:0] rf_m [8];
    logic [3:0] flags_m;
    logic [7:0] out_m;

    function automatic void model_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] r, output logic [3:0] fl);
        int ua, ub, sa, sb, t, sh;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        sh = ub % 8; c = 1'b0; v = 1'b0; t = 0;
        case (op)
            4'd0: begin t = ua + ub; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin t = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: t = ua & ub;
            4'd3: t = ua | ub;
            4'd4: t = ua ^ ub;
            4'd5: t = ua * (1 << sh);
            4'd6: t = ua / (1 << sh);
            4'd7: t = sa >>> sh;
            4'd8: t = (ua < ub) ? 1 : 0;
            4'd9: t = (sa < sb) ? 1 : 0;
            4'd10: t = ub;
            default: t = 0;
        endcase
        r  = t[7:0];
        fl = {v, c, r[7], (r == 8'd0)};
    endfunction

    // Called at a falling edge; drives valid/ready, checks outputs, advances
    // one clock and updates the model for whatever happened at the edge.
    task automatic step(input logic v, input logic rr, output logic acc);
        logic exp_rdy, fire;
        exp_t e;
        cmd_valid = v;
        res_ready = rr;
        #1;
        exp_rdy = (q.size() == 0) || rr;
        chk("cmd_ready", cmd_ready, exp_rdy);
        chk("res_valid", res_valid, q.size() != 0);
        if (q.size() != 0) chk("res_data", res_data, q[0].res);
        chk("flags", flags, flags_m);
        chk("out_port", out_port, out_m);
        fire = (q.size() != 0) && rr;
        acc  = v && exp_rdy;
        @(posedge clk);
        if (fire) begin
            e = q.pop_front();
            if (e.wr && e.rd != 3'd0) rf_m[e.rd] = e.res;
            flags_m = e.fl;
            if (e.out) out_m = e.res;
        end
        if (acc) begin
            logic [7:0] a, b, r;
            logic [3:0] fl;
            logic rsvd;
            a = rf_m[cmd_rs1];
            b = cmd_imm_sel ? cmd_imm : rf_m[cmd_rs2];
            model_alu(cmd_op, a, b, r, fl);
            rsvd = (cmd_op > 4'd10);
            e.res = r; e.fl = fl; e.rd = cmd_rd;
            e.wr = cmd_wr_en && !rsvd; e.out = cmd_out_en && !rsvd;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic isel, input logic [7:0] imm,
                        input logic wr, input logic out);
        logic acc;
        cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_wr_en = wr; cmd_out_en = out;
        acc = 1'b0;
        for (int i = 0; i < 16 && !acc; i++) step(1'b1, 1'b1, acc);
        if (!acc) chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input logic rr);
        logic acc;
        step(1'b0, rr, acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
        cmd_imm_sel = 1'b0; cmd_imm = '0; cmd_wr_en = 1'b0; cmd_out_en = 1'b0;
        for (int i = 0; i < 8; i++) rf_m[i] = 8'd0;
        flags_m = 4'd0; out_m = 8'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_port", out_port, 0);
        rst = 1'b0;

        // Preload and back-to-back forwarding
        send(4'd10, 0, 0, 1, 1, 8'h05, 1, 0);
        send(4'd10, 0, 0, 2, 1, 8'h03, 1, 0);
        send(4'd0, 1, 2, 3, 0, 8'h00, 1, 0);
        chk("add_r1_r2", res_data, 8'h08);

        // Backpressure: ADD held in EX for 3 cycles
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("stall_res", res_data, 8'h08);
            chk("stall_ready", cmd_ready, 0);
        end
        send(4'd1, 3, 2, 4, 0, 8'h00, 1, 0);
        chk("sub_fwd", res_data, 8'h05);
        send(4'd1, 2, 1, 5, 0, 8'h00, 1, 1);
        chk("sub_neg", res_data, 8'hFE);
        idle(1'b1);
        chk("sub_flags", flags, 4'b0110);
        chk("sub_out", out_port, 8'hFE);

        // Overflow and shifts
        send(4'd10, 0, 0, 6, 1, 8'h7F, 1, 0);
        send(4'd0, 6, 0, 7, 1, 8'h01, 1, 0);
        chk("add_ovf", res_data, 8'h80);
        idle(1'b1);
        chk("add_ovf_flags", flags, 4'b1010);
        send(4'd7, 7, 0, 6, 1, 8'h03, 1, 0);
        chk("sra", res_data, 8'hF0);
        send(4'd10, 0, 0, 6, 1, 8'h81, 1, 0);
        send(4'd5, 6, 0, 6, 1, 8'h01, 1, 0);
        chk("shl", res_data, 8'h02);
        send(4'd10, 0, 0, 5, 1, 8'hFF, 1, 0);
        send(4'd9, 5, 0, 0, 1, 8'h01, 0, 0);
        chk("slt", res_data, 8'h01);
        send(4'd8, 5, 0, 0, 1, 8'h01, 0, 0);
        chk("sltu", res_data, 8'h00);

        // r0 and reserved ops
        send(4'd10, 0, 0, 0, 1, 8'hAA, 1, 0);
        send(4'd0, 0, 0, 0, 1, 8'h00, 0, 0);
        chk("r0_zero", res_data, 8'h00);
        send(4'd12, 2, 3, 1, 0, 8'h55, 1, 1);
        chk("rsvd_res", res_data, 8'h00);
        idle(1'b1);
        chk("rsvd_zero_flag", flags[0], 1);
        chk("rsvd_out_kept", out_port, 8'hFE);
        send(4'd0, 1, 0, 0, 1, 8'h00, 0, 0);
        chk("r1_kept", res_data, 8'h05);
        idle(1'b1);

        // Reset with a writing command in EX
        send(4'd10, 0, 0, 2, 1, 8'h5A, 1, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_out", out_port, 0);
        chk("mid_rst_flags", flags, 0);
        q.delete(); flags_m = 4'd0; out_m = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        send(4'd0, 1, 0, 0, 1, 8'h00, 0, 0);
        chk("post_rst_r1", res_data, 8'h05);
        send(4'd0, 2, 0, 0, 1, 8'h00, 0, 0);
        chk("post_rst_r2", res_data, 8'h03);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            cmd_op      = 4'($urandom_range(0, 15));
            cmd_rs1     = 3'($urandom);
            cmd_rs2     = 3'($urandom);
            cmd_rd      = 3'($urandom);
            cmd_imm_sel = 1'($urandom);
            cmd_imm     = 8'($urandom);
            cmd_wr_en   = ($urandom_range(0, 9) < 8);
            cmd_out_en  = 1'($urandom);
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0), acc);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
